// File: rtl/clz_skip_divider.sv
// Iterative restoring unsigned divider with configurable width and radix.
// Define DIVIDER_EARLY_TERMINATE_EN to enable CLZ-based alignment and the dividend<divisor fast path.
module clz_skip_divider #(
   parameter int DATA_WIDTH     = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [DATA_WIDTH-1:0]         dividend,
   input  logic [DATA_WIDTH-1:0]         divisor,
   input  logic [$clog2(DATA_WIDTH)-1:0] dividend_CLZ,
   input  logic [$clog2(DATA_WIDTH)-1:0] divisor_CLZ,
   input  logic                          divisor_is_zero,
   input  logic                          abort,
   output logic                          ready,
   output logic                          done,
   output logic [DATA_WIDTH-1:0]         quotient,
   output logic [DATA_WIDTH-1:0]         remainder
);

   localparam int CLZ_W = $clog2(DATA_WIDTH);
   localparam int CNT_W = CLZ_W + 1;
   localparam int EXT_W = 2 * DATA_WIDTH;

   typedef enum logic {IDLE, COMPUTE} state_t;

   state_t                  state;
   logic [EXT_W-1:0]        shifted_divisor;
   logic [CNT_W-1:0]        count;

   logic                    small_dividend;
   logic [CLZ_W-1:0]        diff;
   logic [CNT_W-1:0]        load_count;
   logic [EXT_W-1:0]        load_divisor;

   logic [DATA_WIDTH-1:0]   step_rem;
   logic [DATA_WIDTH-1:0]   step_quo;
   logic [EXT_W-1:0]        step_div;
   logic [CNT_W-1:0]        step_cnt;

`ifdef DIVIDER_EARLY_TERMINATE_EN
   assign small_dividend = dividend_CLZ > divisor_CLZ;
   assign diff           = divisor_CLZ - dividend_CLZ;
`else
   logic unused_clz;
   assign unused_clz     = ^{dividend_CLZ, divisor_CLZ};
   assign small_dividend = 1'b0;
   assign diff           = CLZ_W'(DATA_WIDTH - 1);
`endif

   // Divisor is kept double width so a full-width alignment never drops bits.
   assign load_count   = {1'b0, diff} + CNT_W'(1);
   assign load_divisor = {{DATA_WIDTH{1'b0}}, divisor} << diff;
   assign ready        = (state == IDLE);

   always_comb begin
      step_rem = remainder;
      step_quo = quotient;
      step_div = shifted_divisor;
      step_cnt = count;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (step_cnt != '0) begin
            if ({{DATA_WIDTH{1'b0}}, step_rem} >= step_div) begin
               step_rem = step_rem - step_div[DATA_WIDTH-1:0];
               step_quo = {step_quo[DATA_WIDTH-2:0], 1'b1};
            end else begin
               step_quo = {step_quo[DATA_WIDTH-2:0], 1'b0};
            end
            step_div = step_div >> 1;
            step_cnt = step_cnt - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         done            <= 1'b0;
         quotient        <= '0;
         remainder       <= '0;
         shifted_divisor <= '0;
         count           <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  if (divisor_is_zero) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     done      <= 1'b1;
                  end else if (small_dividend) begin
                     quotient  <= '0;
                     remainder <= dividend;
                     done      <= 1'b1;
                  end else begin
                     quotient        <= '0;
                     remainder       <= dividend;
                     shifted_divisor <= load_divisor;
                     count           <= load_count;
                     state           <= COMPUTE;
                  end
               end
            end
            COMPUTE: begin
               if (abort) begin
                  state <= IDLE;
                  count <= '0;
               end else begin
                  quotient        <= step_quo;
                  remainder       <= step_rem;
                  shifted_divisor <= step_div;
                  count           <= step_cnt;
                  if (step_cnt == '0) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clz_skip_divider.sv
// Self-checking bench: three divider instances (1, 2 and 4 bits per cycle) share stimulus
// and are compared against an arithmetic reference model of results and latency.
module tb_clz_skip_divider;

   localparam int W = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            abort;
   logic            dz;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic [4:0]      ca;
   logic [4:0]      cb;
   logic [2:0]      rdy;
   logic [2:0]      dn;
   logic [W-1:0]    q [3];
   logic [W-1:0]    r [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clz_skip_divider #(.DATA_WIDTH(W), .BITS_PER_CYCLE(1)) u_b1 (
      .clk(clk), .rst(rst), .start(start), .dividend(a), .divisor(b),
      .dividend_CLZ(ca), .divisor_CLZ(cb), .divisor_is_zero(dz), .abort(abort),
      .ready(rdy[0]), .done(dn[0]), .quotient(q[0]), .remainder(r[0]));

   clz_skip_divider #(.DATA_WIDTH(W), .BITS_PER_CYCLE(2)) u_b2 (
      .clk(clk), .rst(rst), .start(start), .dividend(a), .divisor(b),
      .dividend_CLZ(ca), .divisor_CLZ(cb), .divisor_is_zero(dz), .abort(abort),
      .ready(rdy[1]), .done(dn[1]), .quotient(q[1]), .remainder(r[1]));

   clz_skip_divider #(.DATA_WIDTH(W), .BITS_PER_CYCLE(4)) u_b4 (
      .clk(clk), .rst(rst), .start(start), .dividend(a), .divisor(b),
      .dividend_CLZ(ca), .divisor_CLZ(cb), .divisor_is_zero(dz), .abort(abort),
      .ready(rdy[2]), .done(dn[2]), .quotient(q[2]), .remainder(r[2]));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Leading zeros with zero encoded as W-1.
   function automatic logic [4:0] clz(input logic [W-1:0] v);
      int n = W - 1;
      for (int i = 0; i < W; i++)
         if (v[i]) n = W - 1 - i;
      return 5'(n);
   endfunction

   // Cycles from the sampling edge until done is visible.
   function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y, input int bpc);
      int diff;
      if (y == 0) return 1;
`ifdef DIVIDER_EARLY_TERMINATE_EN
      if (clz(x) > clz(y)) return 1;
      diff = int'(clz(y)) - int'(clz(x));
`else
      diff = W - 1;
`endif
      return (diff + bpc) / bpc + 1;
   endfunction

   task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y);
      a  = x;
      b  = y;
      ca = clz(x);
      cb = clz(y);
      dz = (y == 0);
   endtask

   task automatic run_div(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
      int            lat [3];
      bit            seen [3];
      logic [W-1:0]  eq;
      logic [W-1:0]  er;
      eq = (y == 0) ? '1 : x / y;
      er = (y == 0) ? x : x % y;
      for (int i = 0; i < 3; i++) begin
         seen[i] = 1'b0;
         lat[i]  = exp_lat(x, y, 1 << i);
      end
      drive(x, y);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 80 && !(seen[0] && seen[1] && seen[2]); k++) begin
         for (int i = 0; i < 3; i++) begin
            if (seen[i]) begin
               check($sformatf("%s/b%0d done pulse", tag, 1 << i), dn[i], 1'b0);
               check($sformatf("%s/b%0d q hold", tag, 1 << i), q[i], eq);
               check($sformatf("%s/b%0d r hold", tag, 1 << i), r[i], er);
            end else if (dn[i]) begin
               seen[i] = 1'b1;
               check($sformatf("%s/b%0d latency", tag, 1 << i), k, lat[i]);
               check($sformatf("%s/b%0d quotient", tag, 1 << i), q[i], eq);
               check($sformatf("%s/b%0d remainder", tag, 1 << i), r[i], er);
               check($sformatf("%s/b%0d ready at done", tag, 1 << i), rdy[i], 1'b1);
            end
            if (k == 1 && lat[i] == 1)
               check($sformatf("%s/b%0d ready kept", tag, 1 << i), rdy[i], 1'b1);
         end
         if (!(seen[0] && seen[1] && seen[2])) begin
            @(posedge clk); #1;
         end
      end
      for (int i = 0; i < 3; i++)
         check($sformatf("%s/b%0d completed", tag, 1 << i), seen[i], 1'b1);
   endtask

   initial begin
      logic [W-1:0] x;
      logic [W-1:0] y;

      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      drive(0, 1);
      repeat (2) @(posedge clk);
      #1;
      check("reset ready", rdy, 3'b111);
      check("reset done", dn, 3'b000);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset q b%0d", 1 << i), q[i], 0);
         check($sformatf("reset r b%0d", 1 << i), r[i], 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] directed operands");
      run_div("100/7", 100, 7);
      run_div("div0", 32'h1234, 0);
      run_div("5/9", 5, 9);
      run_div("max/1", 32'hFFFF_FFFF, 1);
      run_div("0/5", 0, 5);
      run_div("0/1", 0, 1);
      run_div("equal", 12345, 12345);
      run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      $display("[TB] abort during compute and restart");
      drive(32'hFFFF_0000, 3);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         check("abort busy", rdy, 3'b000);
         check("abort no done", dn, 3'b000);
         if (k == 3) abort = 1'b1;
         @(posedge clk); #1;
      end
      abort = 1'b0;
      check("abort ready", rdy, 3'b111);
      check("abort no done after", dn, 3'b000);
      run_div("9/3 after abort", 9, 3);

      $display("[TB] abort with same-cycle start");
      drive(100, 7);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         check("dropped start ready", rdy, 3'b111);
         check("dropped start done", dn, 3'b000);
         @(posedge clk); #1;
      end
      drive(32'h1234, 0);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      check("dropped fast path done", dn, 3'b000);

      $display("[TB] reset mid-operation");
      drive(32'hFFFF_FFFF, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k < 5; k++) begin
         check("pre-reset no done", dn, 3'b000);
         @(posedge clk); #1;
      end
      check("pre-reset busy", rdy, 3'b000);
      rst = 1'b1;
      #1;
      check("async reset done", dn, 3'b000);
      check("async reset ready", rdy, 3'b111);
      for (int i = 0; i < 3; i++)
         check($sformatf("async reset q b%0d", 1 << i), q[i], 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         check("post-reset no done", dn, 3'b000);
         @(posedge clk); #1;
      end
      run_div("after reset", 1000, 33);

      $display("[TB] random operands");
      for (int n = 0; n < 24; n++) begin
         x = $urandom;
         y = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 7) == 0) y = 0;
         if ($urandom_range(0, 5) == 0) x = x >> $urandom_range(0, 31);
         run_div($sformatf("rand%0d", n), x, y);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
